// File: rtl/arb_pkg.sv
// Shared types for the arbitrage engine: action and FSM encodings plus position sizing.
package arb_pkg;

  typedef enum logic [1:0] {
    ACT_HOLD = 2'b00,
    ACT_BUY  = 2'b01,
    ACT_SELL = 2'b10
  } action_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIND,
    ST_DECIDE,
    ST_ISSUE,
    ST_COOL
  } state_e;

  localparam int unsigned STAT_W = 32;

  // Signed width able to hold -lim..+lim.
  function automatic int unsigned pos_width(input int unsigned lim);
    return $clog2(lim + 1) + 1;
  endfunction

endpackage

// File: rtl/arb_minmax.sv
// Combinational argmax/argmin over NUM_EX packed prices; ties go to the lowest index.
module arb_minmax
  import arb_pkg::*;
#(
  parameter int unsigned NUM_EX  = 3,
  parameter int unsigned PRICE_W = 16,
  localparam int unsigned IDX_W  = $clog2(NUM_EX)
) (
  input  logic [NUM_EX*PRICE_W-1:0] price_i,
  output logic [PRICE_W-1:0]        max_val_c_o,
  output logic [IDX_W-1:0]          max_idx_c_o,
  output logic [PRICE_W-1:0]        min_val_c_o,
  output logic [IDX_W-1:0]          min_idx_c_o
);

  logic [PRICE_W-1:0] max_v, min_v;
  logic [IDX_W-1:0]   max_i, min_i;

  // Strict compares keep the earliest index on equal prices.
  always_comb begin
    max_v = price_i[PRICE_W-1:0];
    min_v = price_i[PRICE_W-1:0];
    max_i = '0;
    min_i = '0;
    for (int i = 1; i < NUM_EX; i++) begin
      if (price_i[i*PRICE_W +: PRICE_W] > max_v) begin
        max_v = price_i[i*PRICE_W +: PRICE_W];
        max_i = IDX_W'(i);
      end
      if (price_i[i*PRICE_W +: PRICE_W] < min_v) begin
        min_v = price_i[i*PRICE_W +: PRICE_W];
        min_i = IDX_W'(i);
      end
    end
  end

  assign max_val_c_o = max_v;
  assign max_idx_c_o = max_i;
  assign min_val_c_o = min_v;
  assign min_idx_c_o = min_i;

endmodule

// File: rtl/arb_engine.sv
// Registered arbitrage engine: snapshot -> find extremes -> decide -> issue -> cooldown.
// Optional statistics counters are built when ARB_STATS_EN is defined.
module arb_engine
  import arb_pkg::*;
#(
  parameter int unsigned NUM_EX       = 3,
  parameter int unsigned PRICE_W      = 16,
  parameter int unsigned POS_LIM      = 4,
  parameter int unsigned COOLDOWN_CYC = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_EX*PRICE_W-1:0] price_in,
  input  logic [PRICE_W-1:0]        threshold,
  input  logic                      price_valid,
  output logic                      price_ready,
  output logic [2*NUM_EX-1:0]       action_out,
  output logic                      action_valid,
  input  logic                      action_ready,
  input  logic                      clear_pos,
  output logic                      pos_flat,
  output logic [STAT_W-1:0]         trade_count,
  output logic [STAT_W-1:0]         reject_count
);

  localparam int unsigned IDX_W = $clog2(NUM_EX);
  localparam int unsigned POS_W = pos_width(POS_LIM);
  localparam int unsigned SPR_W = PRICE_W + 1;
  localparam int unsigned CNT_W = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
  localparam logic signed [POS_W-1:0] POS_HI  = POS_W'(POS_LIM);
  localparam logic signed [POS_W-1:0] POS_LO  = -POS_HI;
  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

  state_e                      state_q, state_d;
  logic [NUM_EX*PRICE_W-1:0]   price_q, price_d;
  logic [PRICE_W-1:0]          thr_q, thr_d;
  logic [PRICE_W-1:0]          max_val_q, max_val_d, min_val_q, min_val_d;
  logic [IDX_W-1:0]            max_idx_q, max_idx_d, min_idx_q, min_idx_d;
  logic [2*NUM_EX-1:0]         action_q, action_d;
  logic                        action_valid_q, action_valid_d;
  logic                        price_ready_q, price_ready_d;
  logic                        pos_flat_q, pos_flat_d;
  logic signed [POS_W-1:0]     pos_q [NUM_EX];
  logic signed [POS_W-1:0]     pos_d [NUM_EX];
  logic [CNT_W-1:0]            cool_q, cool_d;

  logic [PRICE_W-1:0] mm_max_val, mm_min_val;
  logic [IDX_W-1:0]   mm_max_idx, mm_min_idx;
  logic [SPR_W-1:0]   spread;
  logic               spread_ok, limit_ok, hs;

  arb_minmax #(
    .NUM_EX (NUM_EX),
    .PRICE_W(PRICE_W)
  ) u_minmax (
    .price_i    (price_q),
    .max_val_c_o(mm_max_val),
    .max_idx_c_o(mm_max_idx),
    .min_val_c_o(mm_min_val),
    .min_idx_c_o(mm_min_idx)
  );

  // max >= min always, so the extra bit only guards the full-scale spread.
  assign spread    = {1'b0, max_val_q} - {1'b0, min_val_q};
  assign spread_ok = spread > SPR_W'(thr_q);
  assign limit_ok  = (max_idx_q != min_idx_q) && (pos_q[min_idx_q] < POS_HI)
                     && (pos_q[max_idx_q] > POS_LO);
  assign hs        = action_valid_q && action_ready;

  always_comb begin
    state_d        = state_q;
    price_d        = price_q;
    thr_d          = thr_q;
    max_val_d      = max_val_q;
    max_idx_d      = max_idx_q;
    min_val_d      = min_val_q;
    min_idx_d      = min_idx_q;
    action_d       = action_q;
    action_valid_d = action_valid_q;
    cool_d         = cool_q;
    pos_d          = pos_q;
    pos_flat_d     = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (price_valid && price_ready_q) begin
          price_d = price_in;
          thr_d   = threshold;
          state_d = ST_FIND;
        end
      end
      ST_FIND: begin
        max_val_d = mm_max_val;
        max_idx_d = mm_max_idx;
        min_val_d = mm_min_val;
        min_idx_d = mm_min_idx;
        state_d   = ST_DECIDE;
      end
      ST_DECIDE: begin
        if (spread_ok && limit_ok) begin
          for (int i = 0; i < NUM_EX; i++) begin
            if (IDX_W'(i) == min_idx_q)      action_d[2*i +: 2] = ACT_BUY;
            else if (IDX_W'(i) == max_idx_q) action_d[2*i +: 2] = ACT_SELL;
            else                             action_d[2*i +: 2] = ACT_HOLD;
          end
          action_valid_d = 1'b1;
          state_d        = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (hs) begin
          pos_d[min_idx_q] = pos_q[min_idx_q] + POS_ONE;
          pos_d[max_idx_q] = pos_q[max_idx_q] - POS_ONE;
          action_d         = '0;
          action_valid_d   = 1'b0;
          if (COOLDOWN_CYC > 0) begin
            cool_d  = CNT_W'(COOLDOWN_CYC - 1);
            state_d = ST_COOL;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_COOL: begin
        if (cool_q == '0) state_d = ST_IDLE;
        else              cool_d  = cool_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear overrides any same-cycle trade update.
    if (clear_pos) begin
      for (int i = 0; i < NUM_EX; i++) pos_d[i] = '0;
    end

    for (int i = 0; i < NUM_EX; i++) begin
      if (pos_q[i] != '0) pos_flat_d = 1'b0;
    end

    price_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      price_q        <= '0;
      thr_q          <= '0;
      max_val_q      <= '0;
      max_idx_q      <= '0;
      min_val_q      <= '0;
      min_idx_q      <= '0;
      action_q       <= '0;
      action_valid_q <= 1'b0;
      price_ready_q  <= 1'b0;
      pos_flat_q     <= 1'b1;
      cool_q         <= '0;
      for (int i = 0; i < NUM_EX; i++) pos_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      price_q        <= price_d;
      thr_q          <= thr_d;
      max_val_q      <= max_val_d;
      max_idx_q      <= max_idx_d;
      min_val_q      <= min_val_d;
      min_idx_q      <= min_idx_d;
      action_q       <= action_d;
      action_valid_q <= action_valid_d;
      price_ready_q  <= price_ready_d;
      pos_flat_q     <= pos_flat_d;
      cool_q         <= cool_d;
      pos_q          <= pos_d;
    end
  end

  assign price_ready  = price_ready_q;
  assign action_out   = action_q;
  assign action_valid = action_valid_q;
  assign pos_flat     = pos_flat_q;

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] trade_cnt_q, reject_cnt_q;
  logic              reject_fire;

  assign reject_fire = (state_q == ST_DECIDE) && spread_ok && !limit_ok;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trade_cnt_q  <= '0;
      reject_cnt_q <= '0;
    end else begin
      if (hs && (trade_cnt_q != '1))           trade_cnt_q  <= trade_cnt_q + STAT_W'(1);
      if (reject_fire && (reject_cnt_q != '1)) reject_cnt_q <= reject_cnt_q + STAT_W'(1);
    end
  end

  assign trade_count  = trade_cnt_q;
  assign reject_count = reject_cnt_q;
`else
  assign trade_count  = '0;
  assign reject_count = '0;
`endif

endmodule

// File: tb/tb_arb_engine.sv
// Randomized and directed bench for arb_engine against a high-level trading model.
module tb_arb_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [47:0] price_in = '0;
  logic [15:0] threshold = '0;
  logic        price_valid = 1'b0;
  logic        price_ready;
  logic [5:0]  action_out;
  logic        action_valid;
  logic        action_ready = 1'b0;
  logic        clear_pos = 1'b0;
  logic        pos_flat;
  logic [31:0] trade_count, reject_count;

  logic [95:0] price8 = '0;
  logic [11:0] thr8 = '0;
  logic        pv8 = 1'b0;
  logic        prdy8;
  logic [15:0] act8;
  logic        av8;
  logic        ar8 = 1'b1;
  logic        clr8 = 1'b0;
  logic        flat8;
  logic [31:0] tc8, rc8;

  int checks = 0;
  int failures = 0;
  int mpos[3];
  int mtrades = 0;
  int mrejects = 0;

  always #5 clk = ~clk;

  arb_engine #(.NUM_EX(3), .PRICE_W(16), .POS_LIM(4), .COOLDOWN_CYC(8)) dut (
    .clk(clk), .reset_n(reset_n), .price_in(price_in), .threshold(threshold),
    .price_valid(price_valid), .price_ready(price_ready), .action_out(action_out),
    .action_valid(action_valid), .action_ready(action_ready), .clear_pos(clear_pos),
    .pos_flat(pos_flat), .trade_count(trade_count), .reject_count(reject_count)
  );

  arb_engine #(.NUM_EX(8), .PRICE_W(12), .POS_LIM(4), .COOLDOWN_CYC(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .price_in(price8), .threshold(thr8),
    .price_valid(pv8), .price_ready(prdy8), .action_out(act8),
    .action_valid(av8), .action_ready(ar8), .clear_pos(clr8),
    .pos_flat(flat8), .trade_count(tc8), .reject_count(rc8)
  );

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [47:0] pack3(input int a, input int b, input int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction

  // Spec-level decision: extremes by value, first occurrence, limit gate on positions.
  function automatic void model_decide(input int p[3], input int thr, input int pos[3],
                                       output bit trade, output bit rej,
                                       output logic [5:0] act, output int mx, output int mn);
    int maxv, minv;
    maxv = p[0]; minv = p[0];
    foreach (p[i]) begin
      if (p[i] > maxv) maxv = p[i];
      if (p[i] < minv) minv = p[i];
    end
    mx = -1; mn = -1;
    foreach (p[i]) begin
      if (mx < 0 && p[i] == maxv) mx = i;
      if (mn < 0 && p[i] == minv) mn = i;
    end
    trade = (maxv - minv > thr) && (mx != mn) && (pos[mn] < 4) && (pos[mx] > -4);
    rej   = (maxv - minv > thr) && !trade;
    act = '0;
    if (trade) begin
      act[2*mn +: 2] = 2'b01;
      act[2*mx +: 2] = 2'b10;
    end
  endfunction

  task automatic apply_reset();
    price_valid = 0; action_ready = 0; clear_pos = 0; pv8 = 0;
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (2) @(negedge clk);
    mpos = '{0, 0, 0};
    mtrades = 0;
    mrejects = 0;
  endtask

  task automatic snap(input logic [47:0] p, input logic [15:0] thr, input int wait_cyc,
                      input bit ready_pre, input bit clr_hs,
                      output bit v_n2, output bit v_n3, output logic [5:0] act,
                      output bit rdy_n2, output bit rdy_n3, output bit stable,
                      output bit cleared, output int cool_low);
    int n;
    n = 0;
    while (price_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n >= 100) begin failures++; $display("FAIL ready_timeout got=0 exp=1"); end
    price_in = p; threshold = thr; price_valid = 1; action_ready = ready_pre;
    @(negedge clk); price_valid = 0;
    @(negedge clk); v_n2 = action_valid; rdy_n2 = price_ready;
    @(negedge clk); v_n3 = action_valid; rdy_n3 = price_ready; act = action_out;
    stable = 1; cleared = 1; cool_low = -1;
    if (v_n3) begin
      for (int k = 0; k < wait_cyc; k++) begin
        @(negedge clk);
        if (action_valid !== 1'b1 || action_out !== act) stable = 0;
      end
      action_ready = 1; clear_pos = clr_hs;
      @(negedge clk);
      action_ready = 0; clear_pos = 0;
      cleared = (action_valid === 1'b0) && (action_out === 6'd0);
      n = 0;
      while (price_ready !== 1'b1 && n < 100) begin n++; @(negedge clk); end
      cool_low = n;
    end
    action_ready = 0;
  endtask

  task automatic test_reset();
    reset_n = 1;
    #1 reset_n = 0;
    repeat (2) @(negedge clk);
    checks++; if (price_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0b exp=0", price_ready); end
    checks++; if (action_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", action_valid); end
    checks++; if (action_out !== 6'd0) begin failures++; $display("FAIL rst_action got=%0h exp=0", action_out); end
    checks++; if (pos_flat !== 1'b1) begin failures++; $display("FAIL rst_flat got=%0b exp=1", pos_flat); end
    checks++; if (trade_count !== 0 || reject_count !== 0) begin failures++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", trade_count, reject_count); end
    reset_n = 1;
    repeat (2) @(negedge clk);
    checks++; if (price_ready !== 1'b1) begin failures++; $display("FAIL idle_ready got=%0b exp=1", price_ready); end
  endtask

  task automatic test_basic_trade();
    bit v2, v3, r2, r3, st, cl; logic [5:0] a; int cool;
    apply_reset();
    snap(pack3(110, 100, 105), 16'd5, 0, 1'b1, 1'b0, v2, v3, a, r2, r3, st, cl, cool);
    checks++; if (v2 !== 1'b0) begin failures++; $display("FAIL basic_early got=%0b exp=0", v2); end
    checks++; if (v3 !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", v3); end
    checks++; if (a !== 6'b00_01_10) begin failures++; $display("FAIL basic_action got=%b exp=000110", a); end
    checks++; if (cl !== 1'b1) begin failures++; $display("FAIL basic_cleared got=%0b exp=1", cl); end
    checks++; if (cool != 8) begin failures++; $display("FAIL basic_cooldown got=%0d exp=8", cool); end
    checks++; if (pos_flat !== 1'b0) begin failures++; $display("FAIL basic_flat got=%0b exp=0", pos_flat); end
  endtask

  task automatic test_no_trade();
    bit v2, v3, r2, r3, st, cl; logic [5:0] a; int cool;
    snap(pack3(100, 100, 100), 16'd0, 0, 1'b0, 1'b0, v2, v3, a, r2, r3, st, cl, cool);
    checks++; if (v3 !== 1'b0) begin failures++; $display("FAIL flat_valid got=%0b exp=0", v3); end
    checks++; if (r2 !== 1'b0) begin failures++; $display("FAIL flat_ready_n2 got=%0b exp=0", r2); end
    checks++; if (r3 !== 1'b1) begin failures++; $display("FAIL flat_ready_n3 got=%0b exp=1", r3); end
  endtask

  task automatic test_threshold_edge();
    bit v2, v3, r2, r3, st, cl; logic [5:0] a; int cool;
    apply_reset();
    snap(pack3(120, 100, 110), 16'd20, 0, 1'b0, 1'b0, v2, v3, a, r2, r3, st, cl, cool);
    checks++; if (v3 !== 1'b0) begin failures++; $display("FAIL thr_equal got=%0b exp=0", v3); end
    snap(pack3(120, 100, 110), 16'd19, 1, 1'b0, 1'b0, v2, v3, a, r2, r3, st, cl, cool);
    checks++; if (v3 !== 1'b1) begin failures++; $display("FAIL thr_below got=%0b exp=1", v3); end
    checks++; if (a !== 6'b00_01_10) begin failures++; $display("FAIL thr_action got=%b exp=000110", a); end
  endtask

  task automatic test_pos_limit();
    bit v2, v3, r2, r3, st, cl; logic [5:0] a; int cool;
    apply_reset();
    for (int t = 0; t < 5; t++) begin
      snap(pack3(200, 100, 150), 16'd0, 1, 1'b0, 1'b0, v2, v3, a, r2, r3, st, cl, cool);
      checks++;
      if (v3 !== (t < 4)) begin failures++; $display("FAIL limit_trade%0d got=%0b exp=%0b", t, v3, (t < 4)); end
    end
    checks++; if (pos_flat !== 1'b0) begin failures++; $display("FAIL limit_flat got=%0b exp=0", pos_flat); end
`ifdef ARB_STATS_EN
    checks++; if (reject_count !== 32'd1) begin failures++; $display("FAIL limit_rejects got=%0d exp=1", reject_count); end
    checks++; if (trade_count !== 32'd4) begin failures++; $display("FAIL limit_trades got=%0d exp=4", trade_count); end
`else
    checks++; if (reject_count !== 32'd0 || trade_count !== 32'd0) begin failures++; $display("FAIL stats_off got=%0d/%0d exp=0/0", trade_count, reject_count); end
`endif
    clear_pos = 1;
    @(negedge clk); clear_pos = 0;
    checks++; if (pos_flat !== 1'b0) begin failures++; $display("FAIL clear_lag got=%0b exp=0", pos_flat); end
    @(negedge clk);
    checks++; if (pos_flat !== 1'b1) begin failures++; $display("FAIL clear_flat got=%0b exp=1", pos_flat); end
    snap(pack3(200, 100, 150), 16'd0, 0, 1'b0, 1'b0, v2, v3, a, r2, r3, st, cl, cool);
    checks++; if (v3 !== 1'b1) begin failures++; $display("FAIL post_clear_trade got=%0b exp=1", v3); end
  endtask

  task automatic test_clear_at_handshake();
    bit v2, v3, r2, r3, st, cl; logic [5:0] a; int cool;
    apply_reset();
    snap(pack3(10, 50, 100), 16'd0, 2, 1'b0, 1'b1, v2, v3, a, r2, r3, st, cl, cool);
    checks++; if (a !== 6'b10_00_01) begin failures++; $display("FAIL clrhs_action got=%b exp=100001", a); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL clrhs_stable got=%0b exp=1", st); end
    checks++; if (pos_flat !== 1'b1) begin failures++; $display("FAIL clrhs_flat got=%0b exp=1", pos_flat); end
  endtask

  task automatic test_stall_reset();
    logic [5:0] a; bit st;
    apply_reset();
    price_in = pack3(10, 90, 50); threshold = 16'd0; price_valid = 1;
    @(negedge clk); price_valid = 0;
    repeat (2) @(negedge clk);
    checks++; if (action_valid !== 1'b1) begin failures++; $display("FAIL stall_valid got=%0b exp=1", action_valid); end
    a = action_out; st = 1;
    repeat (10) begin
      @(negedge clk);
      if (action_valid !== 1'b1 || action_out !== a) st = 0;
    end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL stall_stable got=%0b exp=1", st); end
    checks++; if (a !== 6'b00_10_01) begin failures++; $display("FAIL stall_action got=%b exp=001001", a); end
    #2 reset_n = 0;
    #1;
    checks++; if (action_valid !== 1'b0) begin failures++; $display("FAIL async_valid got=%0b exp=0", action_valid); end
    checks++; if (price_ready !== 1'b0) begin failures++; $display("FAIL async_ready got=%0b exp=0", price_ready); end
    @(negedge clk);
    checks++; if (pos_flat !== 1'b1) begin failures++; $display("FAIL async_flat got=%0b exp=1", pos_flat); end
    reset_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wide_snap(input logic [11:0] thr, output bit v, output logic [15:0] a);
    int n;
    int pv[8] = '{5, 4095, 0, 4095, 0, 7, 9, 100};
    for (int i = 0; i < 8; i++) price8[i*12 +: 12] = 12'(pv[i]);
    n = 0;
    while (prdy8 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n >= 100) begin failures++; $display("FAIL wide_ready_timeout got=0 exp=1"); end
    thr8 = thr; pv8 = 1;
    @(negedge clk); pv8 = 0;
    repeat (2) @(negedge clk);
    v = av8; a = act8;
  endtask

  task automatic test_wide();
    bit v; logic [15:0] a;
    wide_snap(12'd4095, v, a);
    checks++; if (v !== 1'b0) begin failures++; $display("FAIL wide_equal got=%0b exp=0", v); end
    wide_snap(12'd4094, v, a);
    checks++; if (v !== 1'b1) begin failures++; $display("FAIL wide_valid got=%0b exp=1", v); end
    checks++; if (a !== 16'h0018) begin failures++; $display("FAIL wide_action got=%h exp=0018", a); end
  endtask

  task automatic test_random();
    bit v2, v3, r2, r3, st, cl, et, er; logic [5:0] a, ea; int cool, mx, mn, thr, w;
    int p[3];
    bit eflat;
    apply_reset();
    for (int it = 0; it < 40; it++) begin
      foreach (p[i]) p[i] = $urandom_range(0, 63);
      thr = $urandom_range(0, 40);
      w = $urandom_range(0, 3);
      model_decide(p, thr, mpos, et, er, ea, mx, mn);
      snap(pack3(p[0], p[1], p[2]), 16'(thr), w, 1'b0, 1'b0, v2, v3, a, r2, r3, st, cl, cool);
      checks++; if (v3 !== et) begin failures++; $display("FAIL rnd%0d_valid got=%0b exp=%0b", it, v3, et); end
      if (et) begin
        checks++; if (a !== ea) begin failures++; $display("FAIL rnd%0d_action got=%b exp=%b", it, a, ea); end
        checks++; if (st !== 1'b1 || cl !== 1'b1) begin failures++; $display("FAIL rnd%0d_hold got=%0b%0b exp=11", it, st, cl); end
        mpos[mn]++; mpos[mx]--; mtrades++;
      end
      if (er) mrejects++;
      eflat = (mpos[0] == 0) && (mpos[1] == 0) && (mpos[2] == 0);
      checks++; if (pos_flat !== eflat) begin failures++; $display("FAIL rnd%0d_flat got=%0b exp=%0b", it, pos_flat, eflat); end
      if (it % 13 == 12) begin
        clear_pos = 1; @(negedge clk); clear_pos = 0; @(negedge clk);
        mpos = '{0, 0, 0};
      end
    end
`ifdef ARB_STATS_EN
    checks++; if (trade_count !== 32'(mtrades)) begin failures++; $display("FAIL rnd_trades got=%0d exp=%0d", trade_count, mtrades); end
    checks++; if (reject_count !== 32'(mrejects)) begin failures++; $display("FAIL rnd_rejects got=%0d exp=%0d", reject_count, mrejects); end
`else
    checks++; if (trade_count !== 32'd0 || reject_count !== 32'd0) begin failures++; $display("FAIL rnd_stats_off got=%0d/%0d exp=0/0", trade_count, reject_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_trade();
    test_no_trade();
    test_threshold_edge();
    test_pos_limit();
    test_clear_at_handshake();
    test_stall_reset();
    test_wide();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arb_engine.md
Name: arb_engine

Overview:
- Parametrised, registered successor to the combinational three-exchange arbitrage decision logic.
- Accepts a snapshot of NUM_EX exchange prices over a valid/ready handshake and finds the highest and lowest quotes.
- Issues a SELL on the highest exchange and a BUY on the lowest when the spread strictly exceeds a programmable threshold, subject to per-exchange position limits and a post-trade cooldown.
- Sits between the HPS price PIOs and the HPS action PIOs.

Parameters:
- NUM_EX, 3: number of exchanges; range 2..16.
- PRICE_W, 16: price width in bits.
- POS_LIM, 4: maximum absolute net position per exchange, in trade units.
- COOLDOWN_CYC, 8: idle cycles after each accepted trade; 0 means no cooldown.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- price_in  in  NUM_EX*PRICE_W  packed prices; exchange i occupies bits [i*PRICE_W +: PRICE_W].
- threshold  in  PRICE_W  minimum spread; trades only when spread > threshold.
- price_valid  in  1  snapshot valid.
- price_ready  out  1  engine can accept a snapshot.
- action_out  out  2*NUM_EX  packed actions, 2 bits per exchange: HOLD=00, BUY=01, SELL=10; 11 is never driven.
- action_valid  out  1  action_out holds a trade.
- action_ready  in  1  consumer accepts the trade.
- clear_pos  in  1  synchronous clear of all positions.
- pos_flat  out  1  high when every position equals 0.
- trade_count  out  32  accepted trades (optional feature).
- reject_count  out  32  snapshots suppressed by the position limit (optional feature).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, price_ready=0 during reset then 1 in IDLE, action_out=0 (all HOLD), action_valid=0, positions=0, pos_flat=1, counters=0.
- Reset asserted mid-operation aborts any pending trade immediately. Positions are not updated for an unaccepted trade.
- price_ready is high only in IDLE. A snapshot is accepted on an edge where price_valid && price_ready; price_in and threshold are captured together at that edge.
- FSM states: IDLE, FIND, DECIDE, ISSUE, COOL.
- IDLE: on accept, go to FIND.
- FIND (1 cycle): register max value/index and min value/index.
  - Ties resolve to the lowest index for both max and min.
- DECIDE (1 cycle): spread = max - min, computed in PRICE_W+1 bits; no wrap is possible.
  - Trade condition: spread > threshold, and max_idx != min_idx, and pos[min_idx] < POS_LIM, and pos[max_idx] > -POS_LIM.
  - Trade true: drive action_out (BUY at min_idx, SELL at max_idx, HOLD elsewhere), assert action_valid, go to ISSUE.
  - Spread fails: return to IDLE silently.
  - Spread passes but limit fails: increment reject_count and return to IDLE.
- Latency: action_valid rises 2 cycles after the accept edge.
- ISSUE: action_out and action_valid hold stable until action_ready.
  - On an edge with action_valid && action_ready (same-cycle ready allowed): pos[min_idx] += 1, pos[max_idx] -= 1, trade_count += 1; clear action_valid and action_out.
  - Then go to COOL if COOLDOWN_CYC > 0, else IDLE.
- COOL: down-counter loaded with COOLDOWN_CYC-1; return to IDLE when it reaches 0. price_ready stays low throughout.
- Positions: signed, width $clog2(POS_LIM+1)+1. They saturate by construction because the limit check precedes the update.
- clear_pos zeroes all positions in any state.
  - If clear_pos coincides with a handshake, the clear wins.
  - A decision already made in DECIDE is not re-evaluated after a clear.
- pos_flat is a registered OR-reduce, 1-cycle lag from a position change.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: trade_count and reject_count are live 32-bit saturating counters (hold at 0xFFFF_FFFF) and are cleared by reset only.
- Undefined: both ports tied to 0 and no counter flops are built.

Decomposition:
- Package arb_pkg: action encodings HOLD/BUY/SELL, state encoding, and a function for position width.
- Sub-module arb_minmax: combinational NUM_EX-input argmax/argmin tree with lowest-index tie-break, registered by the parent in FIND.

Test Plan:
- NUM_EX=3, prices {A=110,B=100,C=105}, threshold=5, action_ready=1 → 2 cycles after accept: action_a=SELL, action_b=BUY, action_c=HOLD; then price_ready low 8 cycles.
- All prices 100, threshold=0 → no action_valid; price_ready back high 2 cycles after accept.
- Spread exactly equal to threshold (120/100, threshold=20) → no trade; threshold=19 → trade.
- Repeat {A=200,B=100,C=150}, threshold=0, five times with POS_LIM=4 → 4 trades; 5th suppressed with reject_count=1; pos_flat=0. Then pulse clear_pos → pos_flat=1 one cycle later, and the next snapshot trades.
- Hold action_ready low 10 cycles in ISSUE → action_out stable; assert reset_n=0 → action_valid=0 asynchronously and positions unchanged.
- NUM_EX=8, PRICE_W=12, prices 4095 and 0 with duplicates of each → max/min pick the lowest-index duplicate; spread 4095 computed without overflow.
